// File: rtl/const_lut_bank_pkg.sv
// Shared types and constants for the banked constant table and its load controller.
// Holds the FSM state type, the bank0 f2i defaults and a helper to slice the packed INIT vector.
package cse141_lut_pkg;

    typedef enum logic [1:0] {
        READY  = 2'd0,
        LOAD   = 2'd1,
        LOCKED = 2'd2
    } lut_state_t;

    localparam logic [7:0] F2I_C0 = 8'h1f;
    localparam logic [7:0] F2I_C1 = 8'h08;
    localparam logic [7:0] F2I_C2 = 8'h19;
    localparam logic [7:0] F2I_C3 = 8'hff;
    localparam logic [7:0] F2I_C4 = 8'h40;
    localparam logic [7:0] F2I_C5 = 8'h41;
    localparam logic [7:0] F2I_C6 = 8'h42;
    localparam logic [7:0] F2I_C7 = 8'h43;

    // Address 0 sits in the least significant byte.
    localparam logic [63:0] F2I_BANK0 = {F2I_C7, F2I_C6, F2I_C5, F2I_C4,
                                         F2I_C3, F2I_C2, F2I_C1, F2I_C0};

    localparam int unsigned INIT_MAX_W = 4096;

    function automatic logic [31:0] init_word(input logic [INIT_MAX_W-1:0] init,
                                              input int unsigned width,
                                              input int unsigned depth,
                                              input int unsigned b,
                                              input int unsigned a);
        logic [INIT_MAX_W-1:0] sh;
        logic [31:0]           w;
        sh = init >> ((b * depth + a) * width);
        w  = sh[31:0];
        if (width < 32) begin
            w = w & ((32'd1 << width) - 32'd1);
        end
        return w;
    endfunction

endpackage

// File: rtl/const_lut_bank_load_ctrl.sv
// Load controller for const_lut_bank: refill FSM, beat counter and deferred-lock flag.
// Drives the storage write port; the write strobe is combinational so a beat lands on its own edge.
//
// state  | meaning
// -------+-----------------------------------------------------------
// READY  | idle, accepts load_start or lock
// LOAD   | load_ready=1, each beat writes entry[bank][cnt], cnt++
// LOCKED | contents frozen, load ports ignored until reset
module lut_load_ctrl
    import cse141_lut_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int BANKS  = 2,
    parameter int BANK_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [BANK_W-1:0] load_bank,
    input  logic              load_valid,
    input  logic              lock,
    output logic              wr_en,
    output logic [BANK_W-1:0] wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              load_ready,
    output logic              locked,
    output logic              err
);

    localparam logic [BANK_W:0]   BANKS_V  = (BANK_W+1)'(BANKS);
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    lut_state_t        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [BANK_W-1:0] bank_q;
    logic              lock_pend_q;
    logic              ready_q;
    logic              locked_q;
    logic              bank_ok;

    assign bank_ok = ({1'b0, load_bank} < BANKS_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= READY;
            cnt_q       <= '0;
            bank_q      <= '0;
            lock_pend_q <= 1'b0;
            ready_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            case (state_q)
                READY: begin
                    // A good load_start beats a simultaneous lock; the lock waits for the table end.
                    if (load_start && bank_ok) begin
                        state_q     <= LOAD;
                        cnt_q       <= '0;
                        bank_q      <= load_bank;
                        lock_pend_q <= lock;
                        ready_q     <= 1'b1;
                    end else if (lock) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (lock) begin
                        lock_pend_q <= 1'b1;
                    end
                    if (load_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q       <= '0;
                            ready_q     <= 1'b0;
                            lock_pend_q <= 1'b0;
                            if (lock_pend_q || lock) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q <= READY;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= READY;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en      = (state_q == LOAD) && load_valid;
    assign wr_bank    = bank_q;
    assign wr_addr    = cnt_q;
    assign load_ready = ready_q;
    assign locked     = locked_q;
    assign err        = load_start && ((state_q != READY) || !bank_ok);

endmodule

// File: rtl/const_lut_bank.sv
// Banked constant table feeding immediates to the datapath; refilled by the program loader.
// Registered reads with write-first forwarding; a sticky error flags bad banks and illegal load starts.
module const_lut_bank
    import cse141_lut_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3,
    parameter int BANKS  = 2,
    parameter logic [BANKS*(2**ADDR_W)*WIDTH-1:0] INIT = (BANKS*(2**ADDR_W)*WIDTH)'(F2I_BANK0),
    localparam int DEPTH  = 2**ADDR_W,
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              load_start,
    input  logic [BANK_W-1:0] load_bank,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    output logic              load_ready,
    input  logic              lock,
    output logic              locked,
    output logic              load_err
);

    localparam logic [BANK_W:0]           BANKS_V  = (BANK_W+1)'(BANKS);
    localparam logic [INIT_MAX_W-1:0]     INIT_EXT = INIT_MAX_W'(INIT);

    logic [WIDTH-1:0]  mem_q [BANKS][DEPTH];
    logic [WIDTH-1:0]  rd_data_q;
    logic [WIDTH-1:0]  rd_data_d;
    logic              rd_valid_q;
    logic              load_err_q;
    logic              load_err_d;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic              ctrl_err;
    logic              rd_bank_ok;
    logic              rd_bad;

    lut_load_ctrl #(
        .ADDR_W (ADDR_W),
        .BANKS  (BANKS),
        .BANK_W (BANK_W)
    ) u_load_ctrl (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_bank  (load_bank),
        .load_valid (load_valid),
        .lock       (lock),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .load_ready (load_ready),
        .locked     (locked),
        .err        (ctrl_err)
    );

    // Reset restores INIT, which also discards any partially loaded table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    mem_q[b][a] <= WIDTH'(init_word(INIT_EXT, WIDTH, DEPTH, b, a));
                end
            end
        end else if (wr_en) begin
            mem_q[wr_bank][wr_addr] <= load_data;
        end
    end

    assign rd_bank_ok = ({1'b0, rd_bank} < BANKS_V);
    assign rd_bad     = rd_en && !rd_bank_ok;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (!rd_bank_ok) begin
                rd_data_d = '0;
            end else if (wr_en && (wr_bank == rd_bank) && (wr_addr == rd_addr)) begin
                rd_data_d = load_data;
            end else begin
                rd_data_d = mem_q[rd_bank][rd_addr];
            end
        end
    end

    assign load_err_d = load_err_q || ctrl_err || rd_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
            load_err_q <= load_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_const_lut_bank.sv
// Self-checking bench for const_lut_bank: scoreboard on the read path plus per-scenario checks.
module tb_const_lut_bank;

    localparam logic [7:0] DEF0 [8] = '{8'h1f, 8'h08, 8'h19, 8'hff, 8'h40, 8'h41, 8'h42, 8'h43};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rd_en = 1'b0;
    logic [0:0] rd_bank = '0;
    logic [2:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       load_start = 1'b0;
    logic [0:0] load_bank = '0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_ready;
    logic       lock = 1'b0;
    logic       locked;
    logic       load_err;

    logic       rd_en3 = 1'b0;
    logic [1:0] rd_bank3 = '0;
    logic [2:0] rd_addr3 = '0;
    logic [7:0] rd_data3;
    logic       rd_valid3;
    logic       load_start3 = 1'b0;
    logic [1:0] load_bank3 = '0;
    logic       load_valid3 = 1'b0;
    logic [7:0] load_data3 = '0;
    logic       load_ready3;
    logic       lock3 = 1'b0;
    logic       locked3;
    logic       load_err3;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_mem [2][8];
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    const_lut_bank u_dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .load_start (load_start),
        .load_bank  (load_bank),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .lock       (lock),
        .locked     (locked),
        .load_err   (load_err)
    );

    const_lut_bank #(.BANKS(3)) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en3),
        .rd_bank    (rd_bank3),
        .rd_addr    (rd_addr3),
        .rd_data    (rd_data3),
        .rd_valid   (rd_valid3),
        .load_start (load_start3),
        .load_bank  (load_bank3),
        .load_valid (load_valid3),
        .load_data  (load_data3),
        .load_ready (load_ready3),
        .lock       (lock3),
        .locked     (locked3),
        .load_err   (load_err3)
    );

    // Read-path scoreboard: every rd_valid cycle consumes one expected word.
    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_valid=1 with nothing expected, rd_data=%h", rd_data);
            end else begin
                automatic logic [7:0] exp = sb.pop_front();
                if (rd_data !== exp) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int a = 0; a < 8; a++) begin
            exp_mem[0][a] = DEF0[a];
            exp_mem[1][a] = 8'h00;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic read_bank(input int b);
        for (int a = 0; a < 8; a++) begin
            rd_en   = 1'b1;
            rd_bank = 1'(b);
            rd_addr = 3'(a);
            sb.push_back(exp_mem[b][a]);
            tick();
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rd_drain: %0d reads never returned, expected 0", sb.size());
        end
    endtask

    task automatic start_load(input int b);
        load_start = 1'b1;
        load_bank  = 1'(b);
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input int b, input int a, input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
        exp_mem[b][a] = d;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd: rd_data=%h rd_valid=%b expected 00/0", rd_data, rd_valid);
        end
        checks++;
        if (load_ready !== 1'b0 || locked !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: load_ready=%b locked=%b load_err=%b expected 0/0/0",
                     load_ready, locked, load_err);
        end
    endtask

    task automatic test_back_to_back();
        read_bank(0);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h43) begin
            errors++;
            $display("FAIL rd_hold: rd_valid=%b rd_data=%h expected 0/43", rd_valid, rd_data);
        end
    endtask

    task automatic test_load_gap();
        start_load(1);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_on: got %b expected 1", load_ready);
        end
        for (int i = 0; i < 8; i++) begin
            beat(1, i, 8'(8'hA0 + i));
            if (i == 3) tick();
        end
        checks++;
        if (load_ready !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL load_done: load_ready=%b locked=%b expected 0/0", load_ready, locked);
        end
        read_bank(1);
        read_bank(0);
    endtask

    task automatic test_write_first();
        start_load(1);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                rd_en   = 1'b1;
                rd_bank = 1'b1;
                rd_addr = 3'd2;
                sb.push_back(8'h5C);
            end
            beat(1, i, 8'(8'h5A + i));
            rd_en = 1'b0;
        end
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL wf_drain: %0d reads pending, expected 0", sb.size());
        end
        read_bank(1);
    endtask

    task automatic test_deferred_lock();
        start_load(1);
        for (int i = 0; i < 4; i++) beat(1, i, 8'(8'hC0 + i));
        lock = 1'b1;
        tick();
        lock = 1'b0;
        checks++;
        if (locked !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL lock_deferred: locked=%b load_ready=%b expected 0/1", locked, load_ready);
        end
        for (int i = 4; i < 8; i++) beat(1, i, 8'(8'hC0 + i));
        checks++;
        if (locked !== 1'b1 || load_ready !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL lock_enter: locked=%b load_ready=%b load_err=%b expected 1/0/0",
                     locked, load_ready, load_err);
        end
        start_load(0);
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = 8'hEE;
            tick();
        end
        load_valid = 1'b0;
        checks++;
        if (load_err !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_err: load_err=%b locked=%b expected 1/1", load_err, locked);
        end
        read_bank(0);
        read_bank(1);
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        start_load(0);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) load_start = 1'b1;
            if (i == 4) begin
                rd_en   = 1'b1;
                rd_bank = 1'b1;
                rd_addr = 3'd0;
                sb.push_back(exp_mem[1][0]);
            end
            beat(0, i, 8'(8'h11 + i));
            load_start = 1'b0;
            rd_en      = 1'b0;
        end
        checks++;
        if (load_err !== 1'b1 || load_ready !== 1'b1 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: load_err=%b load_ready=%b rd_valid=%b expected 1/1/1",
                     load_err, load_ready, rd_valid);
        end
        reset = 1'b1;
        #1;
        sb.delete();
        model_reset();
        checks++;
        if (rd_valid !== 1'b0 || load_err !== 1'b0 || locked !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rd_valid=%b load_err=%b locked=%b load_ready=%b expected 0/0/0/0",
                     rd_valid, load_err, locked, load_ready);
        end
        tick();
        reset = 1'b0;
        tick();
        read_bank(0);
        read_bank(1);
    endtask

    task automatic test_bad_bank();
        rd_en3 = 1'b1; rd_bank3 = 2'd0; rd_addr3 = 3'd3;
        tick();
        checks++;
        if (rd_data3 !== 8'hff || rd_valid3 !== 1'b1 || load_err3 !== 1'b0) begin
            errors++;
            $display("FAIL b3_good: rd_data=%h rd_valid=%b load_err=%b expected ff/1/0",
                     rd_data3, rd_valid3, load_err3);
        end
        rd_bank3 = 2'd2; rd_addr3 = 3'd0;
        tick();
        checks++;
        if (rd_data3 !== 8'h00 || load_err3 !== 1'b0) begin
            errors++;
            $display("FAIL b3_bank2: rd_data=%h load_err=%b expected 00/0", rd_data3, load_err3);
        end
        rd_bank3 = 2'd0; rd_addr3 = 3'd0;
        tick();
        rd_bank3 = 2'd3; rd_addr3 = 3'd0;
        tick();
        rd_en3 = 1'b0;
        checks++;
        if (rd_data3 !== 8'h00 || load_err3 !== 1'b1) begin
            errors++;
            $display("FAIL b3_bad_read: rd_data=%h load_err=%b expected 00/1", rd_data3, load_err3);
        end
        do_reset();
        load_start3 = 1'b1; load_bank3 = 2'd3;
        tick();
        load_start3 = 1'b0;
        checks++;
        if (load_err3 !== 1'b1 || load_ready3 !== 1'b0) begin
            errors++;
            $display("FAIL b3_bad_load: load_err=%b load_ready=%b expected 1/0", load_err3, load_ready3);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_load_gap();
        test_write_first();
        test_deferred_lock();
        test_reset_mid_load();
        test_bad_bank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
